// File: rtl/led_matrix_tick_gen_if.sv
// led_matrix_tick_gen_if
//     Bundles the per-channel control and status signals of led_matrix_tick_gen.
//     master: drives prescale/load/run/oneshot/sync, observes tick/bypass/active/pending.
//     slave : the tick generator itself.
//     prescale : NCH*WIDTH reload values, channel i at [i*WIDTH +: WIDTH]
//     load     : per-channel capture strobe for the prescale slice
//     run      : per-channel run level
//     oneshot  : per-channel mode, 1 = stop after first tick
//     sync     : single-cycle re-alignment pulse for all running channels
//     tick     : one-cycle terminal-count strobe per channel
//     bypass   : active reload equals 0
//     active   : channel is running
//     pending  : shadow reload captured but not yet applied
interface led_matrix_tick_gen_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 16
);
    logic [NCH*WIDTH-1:0] prescale;
    logic [NCH-1:0]       load;
    logic [NCH-1:0]       run;
    logic [NCH-1:0]       oneshot;
    logic                 sync;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       bypass;
    logic [NCH-1:0]       active;
    logic [NCH-1:0]       pending;

    modport master (
        output prescale, load, run, oneshot, sync,
        input  tick, bypass, active, pending
    );

    modport slave (
        input  prescale, load, run, oneshot, sync,
        output tick, bypass, active, pending
    );
endinterface

// File: rtl/led_matrix_tick_gen.sv
// led_matrix_tick_gen
//     Multi-channel prescaler producing independent programmable strobes. Each
//     channel has a double-buffered reload value, continuous or one-shot mode, and
//     all running channels can be re-aligned with a global sync pulse.
//     i_clk  : sole clock
//     i_rst  : synchronous, active-high reset
//     io_bus : control/status bundle (slave side), see led_matrix_tick_gen_if
module led_matrix_tick_gen #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    led_matrix_tick_gen_if.slave        io_bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state  [NCH];
    logic [WIDTH-1:0] r_cnt    [NCH];
    logic [WIDTH-1:0] r_reload [NCH];
    logic [WIDTH-1:0] r_shadow [NCH];
    logic [NCH-1:0]   r_pend;

    state_e           w_state_nxt  [NCH];
    logic [WIDTH-1:0] w_cnt_nxt    [NCH];
    logic [WIDTH-1:0] w_reload_nxt [NCH];
    logic [WIDTH-1:0] w_shadow_nxt [NCH];
    logic [NCH-1:0]   w_pend_nxt;
    logic [NCH-1:0]   w_tc;
    logic [NCH-1:0]   w_apply;

    always_comb begin
        w_tc = '0;
        for (int i = 0; i < NCH; i++) begin
            w_tc[i] = (r_state[i] == StRun) && (r_cnt[i] == r_reload[i]);
        end
    end

    always_comb begin
        w_apply    = '0;
        w_pend_nxt = r_pend;
        for (int i = 0; i < NCH; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_cnt_nxt[i]    = r_cnt[i];
            w_reload_nxt[i] = r_reload[i];
            w_shadow_nxt[i] = r_shadow[i];

            unique case (r_state[i])
                StIdle: begin
                    w_cnt_nxt[i] = '0;
                    if (io_bus.run[i]) begin
                        w_state_nxt[i] = StRun;
                    end
                end
                StRun: begin
                    if (!io_bus.run[i]) begin
                        w_state_nxt[i] = StIdle;
                        w_cnt_nxt[i]   = '0;
                        w_apply[i]     = 1'b1;
                    end else if (io_bus.sync) begin
                        // Sync wins over tc: state kept, counter restarted.
                        w_cnt_nxt[i] = '0;
                        w_apply[i]   = 1'b1;
                    end else if (w_tc[i]) begin
                        w_cnt_nxt[i] = '0;
                        w_apply[i]   = 1'b1;
                        if (io_bus.oneshot[i]) begin
                            w_state_nxt[i] = StDone;
                        end
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + WIDTH'(1);
                    end
                end
                default: begin
                    w_cnt_nxt[i] = '0;
                    if (!io_bus.run[i]) begin
                        w_state_nxt[i] = StIdle;
                    end
                end
            endcase

            // A load at an apply point bypasses the shadow so the newest value wins.
            if (io_bus.load[i]) begin
                if (r_state[i] != StRun || w_apply[i]) begin
                    w_reload_nxt[i] = io_bus.prescale[i*WIDTH +: WIDTH];
                    w_pend_nxt[i]   = 1'b0;
                end else begin
                    w_shadow_nxt[i] = io_bus.prescale[i*WIDTH +: WIDTH];
                    w_pend_nxt[i]   = 1'b1;
                end
            end else if (w_apply[i] && r_pend[i]) begin
                w_reload_nxt[i] = r_shadow[i];
                w_pend_nxt[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= StIdle;
                r_cnt[i]    <= '0;
                r_reload[i] <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_nxt;
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_cnt[i]    <= w_cnt_nxt[i];
                r_reload[i] <= w_reload_nxt[i];
                r_shadow[i] <= w_shadow_nxt[i];
            end
        end
    end

    always_comb begin
        io_bus.tick    = '0;
        io_bus.bypass  = '0;
        io_bus.active  = '0;
        io_bus.pending = r_pend;
        for (int i = 0; i < NCH; i++) begin
            io_bus.tick[i]   = w_tc[i] && !io_bus.sync;
            io_bus.bypass[i] = (r_reload[i] == '0);
            io_bus.active[i] = (r_state[i] == StRun);
        end
    end
endmodule

// File: tb/tb_led_matrix_tick_gen.sv
// tb_led_matrix_tick_gen
//     Directed scenarios followed by randomized traffic, checked against a
//     countdown-based reference model of each channel.
module tb_led_matrix_tick_gen;
    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_matrix_tick_gen_if #(.NCH(NCH), .WIDTH(W)) bus ();

    led_matrix_tick_gen #(.NCH(NCH), .WIDTH(W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus for the next cycle; load/sync/rst are pulses cleared after each step.
    logic [NCH*W-1:0] v_ps;
    logic [NCH-1:0]   v_ld, v_run, v_os;
    logic             v_sync, v_rst;

    // Model: mode 0 idle, 1 running, 2 finished; m_rem = cycles left until the tick.
    int               m_mode [NCH];
    logic [W-1:0]     m_rem  [NCH];
    logic [W-1:0]     m_rel  [NCH];
    logic [W-1:0]     m_shd  [NCH];
    bit               m_pend [NCH];

    logic [NCH-1:0]   obs_tick, obs_byp, obs_act, obs_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ps(input int ch, input logic [W-1:0] val);
        v_ps[ch*W +: W] = val;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 0;
            m_rem[i]  = '0;
            m_rel[i]  = '0;
            m_shd[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            logic [W-1:0] sl;
            bit           bnd;
            sl = v_ps[i*W +: W];
            if (v_rst) begin
                m_mode[i] = 0;
                m_rem[i]  = '0;
                m_rel[i]  = '0;
                m_shd[i]  = '0;
                m_pend[i] = 1'b0;
            end else begin
                case (m_mode[i])
                    0: begin
                        if (v_ld[i]) m_rel[i] = sl;
                        if (v_run[i]) begin
                            m_mode[i] = 1;
                            m_rem[i]  = m_rel[i];
                        end
                    end
                    1: begin
                        bnd = !v_run[i] || v_sync || (m_rem[i] == 0);
                        if (bnd) begin
                            if (v_ld[i]) m_rel[i] = sl;
                            else if (m_pend[i]) m_rel[i] = m_shd[i];
                            m_pend[i] = 1'b0;
                        end else if (v_ld[i]) begin
                            m_shd[i]  = sl;
                            m_pend[i] = 1'b1;
                        end
                        if (!v_run[i]) m_mode[i] = 0;
                        else if (v_sync) m_rem[i] = m_rel[i];
                        else if (m_rem[i] == 0) begin
                            if (v_os[i]) m_mode[i] = 2;
                            else m_rem[i] = m_rel[i];
                        end else m_rem[i] = m_rem[i] - 1'b1;
                    end
                    default: begin
                        if (v_ld[i]) m_rel[i] = sl;
                        if (!v_run[i]) m_mode[i] = 0;
                    end
                endcase
            end
        end
    endtask

    // One clock cycle: drive, compare against model, advance model, cross the edge.
    task automatic step();
        logic [NCH-1:0] e_tick, e_byp, e_act, e_pend;
        @(negedge clk);
        bus.prescale = v_ps;
        bus.load     = v_ld;
        bus.run      = v_run;
        bus.oneshot  = v_os;
        bus.sync     = v_sync;
        rst          = v_rst;
        #1;
        for (int i = 0; i < NCH; i++) begin
            e_tick[i] = (m_mode[i] == 1) && (m_rem[i] == 0) && !v_sync;
            e_byp[i]  = (m_rel[i] == 0);
            e_act[i]  = (m_mode[i] == 1);
            e_pend[i] = m_pend[i];
        end
        obs_tick = bus.tick;
        obs_byp  = bus.bypass;
        obs_act  = bus.active;
        obs_pend = bus.pending;
        chk("tick",    32'(obs_tick), 32'(e_tick));
        chk("bypass",  32'(obs_byp),  32'(e_byp));
        chk("active",  32'(obs_act),  32'(e_act));
        chk("pending", 32'(obs_pend), 32'(e_pend));
        model_edge();
        v_ld   = '0;
        v_sync = 1'b0;
        v_rst  = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int cnt;
        v_ps = '0; v_ld = '0; v_run = '0; v_os = '0; v_sync = 1'b0; v_rst = 1'b0;
        bus.prescale = '0; bus.load = '0; bus.run = '0; bus.oneshot = '0; bus.sync = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        step();
        chk("rst_bypass", 32'(obs_byp), 32'hF);
        chk("rst_tick", 32'(obs_tick), 32'h0);

        // Channel 0, reload 3: ticks on cycles 3, 7, 11 after the run edge
        set_ps(0, 3); v_ld[0] = 1'b1; step();
        v_run[0] = 1'b1; step();
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t1_tick0", 32'(obs_tick[0]), 32'((k % 4) == 3));
            if (k == 0) begin
                chk("t1_act0", 32'(obs_act[0]), 32'd1);
                chk("t1_byp0", 32'(obs_byp[0]), 32'd0);
            end
        end
        v_run[0] = 1'b0; step();

        // Channel 1, reload 4, reload 1 loaded at cnt=2
        set_ps(1, 4); v_ld[1] = 1'b1; step();
        v_run[1] = 1'b1; step();
        step(); step();
        set_ps(1, 1); v_ld[1] = 1'b1; step();
        for (int k = 3; k < 10; k++) begin
            step();
            chk("t2_tick1", 32'(obs_tick[1]), 32'(k == 4 || k == 6 || k == 8));
            chk("t2_pend1", 32'(obs_pend[1]), 32'(k <= 4));
        end
        v_run[1] = 1'b0; step();

        // Channel 2 one-shot, reload 2
        set_ps(2, 2); v_ld[2] = 1'b1; v_os[2] = 1'b1; step();
        v_run[2] = 1'b1; step();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin step(); cnt += int'(obs_tick[2]); end
        chk("t3_once", 32'(cnt), 32'd1);
        chk("t3_done_act", 32'(obs_act[2]), 32'd0);
        v_run[2] = 1'b0; step();
        v_run[2] = 1'b1; step();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin step(); cnt += int'(obs_tick[2]); end
        chk("t3_again", 32'(cnt), 32'd1);
        v_run[2] = 1'b0; v_os[2] = 1'b0; step();

        // Channels 0/1 out of phase, then sync
        set_ps(0, 5); set_ps(1, 7); v_ld[1:0] = 2'b11; step();
        v_run[0] = 1'b1; step(); step(); step();
        v_run[1] = 1'b1; step(); step(); step();
        v_sync = 1'b1; step();
        chk("t4_sync_mask", 32'(obs_tick), 32'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t4_tick0", 32'(obs_tick[0]), 32'(k == 5));
            chk("t4_tick1", 32'(obs_tick[1]), 32'(k == 7));
        end
        v_run[1:0] = 2'b00; step();

        // Channel 3: reload 0 runs every cycle; then load 0 at a tc of reload 2
        set_ps(3, 0); v_ld[3] = 1'b1; step();
        v_run[3] = 1'b1; step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_tick3", 32'(obs_tick[3]), 32'd1);
            chk("t5_byp3", 32'(obs_byp[3]), 32'd1);
        end
        v_run[3] = 1'b0; step();
        set_ps(3, 2); v_ld[3] = 1'b1; step();
        v_run[3] = 1'b1; step();
        step(); step();
        set_ps(3, 0); v_ld[3] = 1'b1; step();
        chk("t5_tc_tick", 32'(obs_tick[3]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_fast_tick", 32'(obs_tick[3]), 32'd1);
            chk("t5_no_pend", 32'(obs_pend[3]), 32'd0);
        end
        v_run[3] = 1'b0; step();

        // Reset mid-count with a pending shadow
        set_ps(0, 6); v_ld[0] = 1'b1; step();
        v_run[0] = 1'b1; step(); step(); step();
        set_ps(0, 3); v_ld[0] = 1'b1; step();
        step();
        chk("t6_pend_before", 32'(obs_pend[0]), 32'd1);
        v_rst = 1'b1; v_sync = 1'b1; v_ld[0] = 1'b1; step();
        step();
        chk("t6_tick", 32'(obs_tick), 32'h0);
        chk("t6_act", 32'(obs_act), 32'h0);
        chk("t6_pend", 32'(obs_pend), 32'h0);
        chk("t6_byp", 32'(obs_byp), 32'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_every", 32'(obs_tick[0]), 32'd1);
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            v_rst  = ($urandom_range(0, 199) == 0);
            v_sync = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 11) == 0) v_run[i] = ~v_run[i];
                if ($urandom_range(0, 39) == 0) v_os[i] = ~v_os[i];
                v_ld[i] = ($urandom_range(0, 6) == 0);
                set_ps(i, W'($urandom_range(0, 6)));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
